// File: rtl/axi_stream_strip_header.sv
// AXI-Stream header stripper: drops S leading bytes from each packet and realigns the payload to the MSB lane.
// Optional AXIS_STRIP_ERR_CHECK_EN adds a sticky keep-protocol error flag on err_out.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip,
    output logic                    hdr_valid,
    output logic [DATA_WD-1:0]      hdr_data,
    output logic [DATA_BYTE_WD-1:0] hdr_keep,
    output logic                    runt_pulse,
    output logic                    err_out
);

    localparam int SHW = $clog2(DATA_WD) + 1;
    localparam int KW  = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {S_CFG, S_FIRST, S_BODY, S_FLUSH} state_t;

    state_t                  r_state, w_nextState;
    logic [BYTE_CNT_WD-1:0]  r_strip;
    logic [DATA_WD-1:0]      r_hold;
    logic [DATA_BYTE_WD-1:0] r_holdKeep;
    logic                    r_validOut, r_lastOut, r_hdrValid, r_runt;
    logic [DATA_WD-1:0]      r_dataOut, r_hdrData;
    logic [DATA_BYTE_WD-1:0] r_keepOut, r_hdrKeep;

    logic                    w_canLoad, w_accept;
    logic [BYTE_CNT_WD+2:0]  w_shiftBits;
    logic [SHW-1:0]          w_tailBits;
    logic [KW-1:0]           w_tailLanes;
    logic [DATA_WD-1:0]      w_shiftUp;
    logic [DATA_BYTE_WD-1:0] w_rem, w_hdrMask;

    logic                    w_load, w_newLast, w_holdLoad, w_runt, w_firstAccept;
    logic [DATA_WD-1:0]      w_newData, w_newHold;
    logic [DATA_BYTE_WD-1:0] w_newKeep, w_newHoldKeep;

    function automatic logic [DATA_WD-1:0] expandKeep(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    assign w_canLoad   = !r_validOut || ready_out;
    assign ready_in    = (r_state == S_FIRST || r_state == S_BODY) && w_canLoad;
    assign ready_strip = (r_state == S_CFG);
    assign w_accept    = valid_in && ready_in;

    // Lanes S..N-1 of the incoming beat move up to the MSB; w_rem is nonzero when any of them are valid.
    assign w_shiftBits = {r_strip, 3'b000};
    assign w_tailBits  = SHW'(DATA_WD) - SHW'(w_shiftBits);
    assign w_tailLanes = KW'(DATA_BYTE_WD) - KW'(r_strip);
    assign w_shiftUp   = data_in << w_shiftBits;
    assign w_rem       = keep_in << r_strip;
    assign w_hdrMask   = ~({DATA_BYTE_WD{1'b1}} >> r_strip);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_CFG;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState   = r_state;
        w_load        = 1'b0;
        w_newData     = '0;
        w_newKeep     = '0;
        w_newLast     = 1'b0;
        w_holdLoad    = 1'b0;
        w_newHold     = '0;
        w_newHoldKeep = '0;
        w_runt        = 1'b0;
        w_firstAccept = 1'b0;
        case (r_state)
            S_CFG: begin
                if (valid_strip) w_nextState = S_FIRST;
            end
            S_FIRST: begin
                if (w_accept) begin
                    w_firstAccept = 1'b1;
                    if (r_strip == '0) begin
                        w_load      = 1'b1;
                        w_newData   = data_in;
                        w_newKeep   = keep_in;
                        w_newLast   = last_in;
                        w_nextState = last_in ? S_CFG : S_BODY;
                    end else if (!last_in) begin
                        w_holdLoad    = 1'b1;
                        w_newHold     = w_shiftUp;
                        w_newHoldKeep = w_rem;
                        w_nextState   = S_BODY;
                    end else if (w_rem == '0) begin
                        w_runt      = 1'b1;
                        w_nextState = S_CFG;
                    end else begin
                        w_load      = 1'b1;
                        w_newData   = w_shiftUp;
                        w_newKeep   = w_rem;
                        w_newLast   = 1'b1;
                        w_nextState = S_CFG;
                    end
                end
            end
            S_BODY: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (r_strip == '0) begin
                        w_newData = data_in;
                        w_newKeep = keep_in;
                        w_newLast = last_in;
                        if (last_in) w_nextState = S_CFG;
                    end else begin
                        // Held bytes on top, first S lanes of the new beat fill the tail.
                        w_newData     = r_hold | (data_in >> w_tailBits);
                        w_newKeep     = r_holdKeep | (keep_in >> w_tailLanes);
                        w_holdLoad    = 1'b1;
                        w_newHold     = w_shiftUp;
                        w_newHoldKeep = w_rem;
                        if (last_in) begin
                            if (w_rem == '0) begin
                                w_newLast   = 1'b1;
                                w_nextState = S_CFG;
                            end else begin
                                w_nextState = S_FLUSH;
                            end
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (w_canLoad) begin
                    w_load      = 1'b1;
                    w_newData   = r_hold;
                    w_newKeep   = r_holdKeep;
                    w_newLast   = 1'b1;
                    w_nextState = S_CFG;
                end
            end
            default: w_nextState = S_CFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_validOut <= 1'b0;
            r_dataOut  <= '0;
            r_keepOut  <= '0;
            r_lastOut  <= 1'b0;
            r_hold     <= '0;
            r_holdKeep <= '0;
            r_strip    <= '0;
            r_hdrValid <= 1'b0;
            r_hdrData  <= '0;
            r_hdrKeep  <= '0;
            r_runt     <= 1'b0;
        end else begin
            if (w_load) begin
                r_validOut <= 1'b1;
                r_dataOut  <= w_newData & expandKeep(w_newKeep);
                r_keepOut  <= w_newKeep;
                r_lastOut  <= w_newLast;
            end else if (ready_out) begin
                r_validOut <= 1'b0;
            end
            if (w_holdLoad) begin
                r_hold     <= w_newHold;
                r_holdKeep <= w_newHoldKeep;
            end
            if (r_state == S_CFG && valid_strip) r_strip <= byte_strip_cnt;
            r_hdrValid <= w_firstAccept;
            if (w_firstAccept) begin
                r_hdrData <= data_in & expandKeep(keep_in & w_hdrMask);
                r_hdrKeep <= keep_in & w_hdrMask;
            end
            r_runt <= w_runt;
        end
    end

    assign valid_out  = r_validOut;
    assign data_out   = r_dataOut;
    assign keep_out   = r_keepOut;
    assign last_out   = r_lastOut;
    assign hdr_valid  = r_hdrValid;
    assign hdr_data   = r_hdrData;
    assign hdr_keep   = r_hdrKeep;
    assign runt_pulse = r_runt;

`ifdef AXIS_STRIP_ERR_CHECK_EN
    logic                    r_err;
    logic [DATA_BYTE_WD-1:0] w_invKeep, w_invKeepInc;
    logic                    w_badKeep;

    // A valid last-beat keep is ones-then-zeros, so its inverse plus one must be a power of two.
    assign w_invKeep    = ~keep_in;
    assign w_invKeepInc = w_invKeep + 1'b1;
    assign w_badKeep    = last_in ? ((keep_in == '0) || ((w_invKeep & w_invKeepInc) != '0))
                                  : (keep_in != {DATA_BYTE_WD{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_err <= 1'b0;
        else if (w_accept && w_badKeep) r_err <= 1'b1;
    end

    assign err_out = r_err;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench for axi_stream_strip_header: per-cycle vector table plus stall, reset and error sequences.
module tb_axi_stream_strip_header;

    logic        clk, rst_n;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_strip, ready_strip;
    logic [1:0]  byte_strip_cnt;
    logic        hdr_valid, runt_pulse, err_out;
    logic [31:0] hdr_data;
    logic [3:0]  hdr_keep;

    int checks   = 0;
    int failures = 0;

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
        .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_keep(hdr_keep),
        .runt_pulse(runt_pulse), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle; readiness expected before the edge, registered outputs after it.
    typedef struct packed {
        logic        vs;
        logic [1:0]  sc;
        logic        vi;
        logic [31:0] di;
        logic [3:0]  ki;
        logic        li;
        logic        ro;
        logic        eRdyIn;
        logic        eRdyStrip;
        logic        eVo;
        logic [31:0] eDo;
        logic [3:0]  eKo;
        logic        eLo;
        logic        eHv;
        logic [31:0] eHd;
        logic [3:0]  eHk;
        logic        eRunt;
    } vec_t;

    vec_t vecs [14];

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        valid_strip    = v.vs;
        byte_strip_cnt = v.sc;
        valid_in       = v.vi;
        data_in        = v.di;
        keep_in        = v.ki;
        last_in        = v.li;
        ready_out      = v.ro;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkBit({tag, ".valid_out"}, valid_out, v.eVo);
        if (v.eVo) begin
            checkWord({tag, ".data_out"}, data_out, v.eDo);
            checkWord({tag, ".keep_out"}, 32'(keep_out), 32'(v.eKo));
            checkBit({tag, ".last_out"}, last_out, v.eLo);
        end
        checkBit({tag, ".hdr_valid"}, hdr_valid, v.eHv);
        if (v.eHv) begin
            checkWord({tag, ".hdr_data"}, hdr_data, v.eHd);
            checkWord({tag, ".hdr_keep"}, 32'(hdr_keep), 32'(v.eHk));
        end
        checkBit({tag, ".runt_pulse"}, runt_pulse, v.eRunt);
    endtask

    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkBit($sformatf("vec%0d.ready_in", i), ready_in, vecs[i].eRdyIn);
            checkBit($sformatf("vec%0d.ready_strip", i), ready_strip, vecs[i].eRdyStrip);
            @(posedge clk);
            #1;
            checkOutput(vecs[i], i);
        end
    endtask

    task automatic idleInputs();
        valid_strip    = 1'b0;
        byte_strip_cnt = 2'd0;
        valid_in       = 1'b0;
        data_in        = 32'h0;
        keep_in        = 4'h0;
        last_in        = 1'b0;
        ready_out      = 1'b1;
    endtask

    logic [31:0] stBeats  [4];
    logic [31:0] stExpD   [4];
    logic [3:0]  stExpK   [4];
    logic        stExpL   [4];
    logic        roPattern[4];

    initial begin
        //                 vs    sc    vi    di            ki     li    ro    rIn   rStr  vo    do            ko     lo    hv    hd            hk     runt
        vecs[0]  = '{1'b1, 2'd1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'hAA000000, 4'h8, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h11223344, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hBBCCDD11, 4'hF, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22334400, 4'hE, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[4]  = '{1'b1, 2'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22334400, 4'hE, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'hAABB0000, 4'hC, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h11223344, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCCDD1122, 4'hF, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 32'h01020304, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h01020304, 4'hF, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h01020304, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h01020304, 4'hF, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 32'h01020304, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h01020300, 4'hE, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[11] = '{1'b1, 2'd3, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 32'hAABBCCDD, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'hAABB0000, 4'hC, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};

        stBeats = '{32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h99AABBCC};
        stExpD  = '{32'hBBCCDD11, 32'h22334455, 32'h66778899, 32'hAABBCC00};
        stExpK  = '{4'hF, 4'hF, 4'hF, 4'hE};
        stExpL  = '{1'b0, 1'b0, 1'b0, 1'b1};
        roPattern = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkBit("reset.valid_out", valid_out, 1'b0);
        checkBit("reset.ready_strip", ready_strip, 1'b1);
        checkBit("reset.ready_in", ready_in, 1'b0);
        checkBit("reset.hdr_valid", hdr_valid, 1'b0);
        checkWord("reset.data_out", data_out, 32'h0);
        checkBit("reset.err_out", err_out, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runVectors(0, 13);

        // S=1, four beats with ready_out toggling 1,0,0,1.
        begin
            int inIdx, outIdx;
            logic        stalled;
            logic [31:0] heldData;
            inIdx = 0;
            outIdx = 0;
            stalled = 1'b0;
            heldData = 32'h0;
            valid_strip = 1'b1;
            byte_strip_cnt = 2'd1;
            @(posedge clk);
            #1;
            valid_strip = 1'b0;
            for (int cyc = 0; cyc < 40 && outIdx < 4; cyc++) begin
                ready_out = roPattern[cyc % 4];
                valid_in  = (inIdx < 4);
                data_in   = (inIdx < 4) ? stBeats[inIdx] : 32'h0;
                keep_in   = (inIdx < 4) ? 4'hF : 4'h0;
                last_in   = (inIdx == 3);
                #1;
                if (stalled) begin
                    checkBit("stall.valid_held", valid_out, 1'b1);
                    checkWord("stall.data_held", data_out, heldData);
                end
                if (valid_out && !ready_out) checkBit("stall.ready_in", ready_in, 1'b0);
                if (valid_out && ready_out) begin
                    checkWord($sformatf("stall.data%0d", outIdx), data_out, stExpD[outIdx]);
                    checkWord($sformatf("stall.keep%0d", outIdx), 32'(keep_out), 32'(stExpK[outIdx]));
                    checkBit($sformatf("stall.last%0d", outIdx), last_out, stExpL[outIdx]);
                    outIdx++;
                end
                stalled  = valid_out && !ready_out;
                heldData = data_out;
                if (valid_in && ready_in) inIdx++;
                @(posedge clk);
                #1;
            end
            checkWord("stall.beats_out", 32'(outIdx), 32'd4);
            idleInputs();
            @(posedge clk);
            #1;
        end

        // Reset while in BODY with a beat pending, then rerun the S=1 packet.
        valid_strip = 1'b1;
        byte_strip_cnt = 2'd1;
        ready_out = 1'b0;
        @(posedge clk);
        #1;
        valid_strip = 1'b0;
        valid_in = 1'b1;
        data_in = 32'hAABBCCDD;
        keep_in = 4'hF;
        last_in = 1'b0;
        @(posedge clk);
        #1;
        data_in = 32'h11223344;
        @(posedge clk);
        #1;
        checkBit("midreset.valid_before", valid_out, 1'b1);
        valid_in = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkBit("midreset.valid_out", valid_out, 1'b0);
        checkBit("midreset.ready_strip", ready_strip, 1'b1);
        checkBit("midreset.ready_in", ready_in, 1'b0);
        #1;
        rst_n = 1'b1;
        idleInputs();
        @(posedge clk);
        #1;
        runVectors(0, 3);
        idleInputs();
        @(posedge clk);
        #1;
        checkBit("err.clean", err_out, 1'b0);

`ifdef AXIS_STRIP_ERR_CHECK_EN
        valid_strip = 1'b1;
        byte_strip_cnt = 2'd0;
        @(posedge clk);
        #1;
        valid_strip = 1'b0;
        valid_in = 1'b1;
        data_in = 32'h01020304;
        keep_in = 4'hE;
        last_in = 1'b0;
        @(posedge clk);
        #1;
        checkBit("err.set", err_out, 1'b1);
        keep_in = 4'hF;
        last_in = 1'b1;
        @(posedge clk);
        #1;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        checkBit("err.sticky", err_out, 1'b1);
`else
        checkBit("err.tied_low", err_out, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
